// File: rtl/fp_to_int_pkg.sv
// Shared widths, range limits and the packed 13-bit float operand type
// for the fp_to_int converter.
package fp_to_int_pkg;

  localparam int EXP_W       = 4;
  localparam int FRAC_W      = 8;
  localparam int INT_W       = 8;
  localparam int MAG_W       = 16;   // wide enough that no shift result is lost
  localparam int INT_MAX     = 127;  // largest positive result
  localparam int INT_MIN_MAG = 128;  // magnitude of the most negative result

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp13_t;

endpackage

// File: rtl/fp_to_int_mag_shift.sv
// fp_mag_shift: combinational barrel shifter producing |value| truncated
// toward zero, i.e. floor(0.frac * 2^exp), as a 16-bit magnitude.
// o_big flags a magnitude that does not fit in INT_W bits at all; it can
// only be set once exp reaches 16-8 or more.
module fp_mag_shift
  import fp_to_int_pkg::*;
(
  input  logic [FRAC_W-1:0] i_frac,
  input  logic [EXP_W-1:0]  i_exp,
  output logic [MAG_W-1:0]  o_mag,
  output logic              o_big
);

  // frac sits in the low byte as a fraction; shifting left by exp and
  // dropping the low FRAC_W bits covers both the right-shift (exp<=8)
  // and left-shift (exp>8) cases in one path.
  logic [MAG_W+FRAC_W-1:0] w_ext;

  // Shift and drop the fractional part.
  always_comb begin
    w_ext = {{MAG_W{1'b0}}, i_frac} << i_exp;
    o_mag = w_ext[MAG_W+FRAC_W-1:FRAC_W];
    o_big = |o_mag[MAG_W-1:INT_W];
  end

endmodule

// File: rtl/fp_to_int.sv
// fp_to_int: 13-bit sign-magnitude float {sign, exp[3:0], frac[7:0]} to
// 8-bit two's-complement integer, truncated toward zero, 1-cycle latency.
// Optional build macro FP_TO_INT_SAT_EN: saturate on overflow instead of
// returning zero. The of flag is the same in both builds.
module fp_to_int
  import fp_to_int_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              sign,
  input  logic [EXP_W-1:0]  exp,
  input  logic [FRAC_W-1:0] frac,
  output logic              out_valid,
  output logic [INT_W-1:0]  integ,
  output logic              uf,
  output logic              of
);

  fp13_t              w_in;
  logic [MAG_W-1:0]   w_mag;
  logic               w_big;
  logic               w_zero;
  logic               w_uf;
  logic               w_of;
  logic [INT_W-1:0]   w_lo;
  logic [INT_W-1:0]   w_integ;

  logic               r_vld;
  logic [INT_W-1:0]   r_integ;
  logic               r_uf;
  logic               r_of;

  assign w_in = {sign, exp, frac};

  fp_mag_shift u_shift (
    .i_frac (w_in.frac),
    .i_exp  (w_in.exp),
    .o_mag  (w_mag),
    .o_big  (w_big)
  );

  // Range check, flag generation and sign application.
  always_comb begin
    w_lo    = w_mag[INT_W-1:0];
    w_zero  = (w_in.frac == '0);
    // Nonzero operand whose integer part truncates to nothing.
    w_uf    = !w_zero && (w_mag == '0);
    // Negative side reaches one further than positive (-128 is legal).
    w_of    = !w_zero && (w_big ||
              (w_in.sign ? (w_lo > INT_W'(INT_MIN_MAG)) : (w_lo > INT_W'(INT_MAX))));
    w_integ = '0;
    if (w_zero || w_uf) begin
      w_integ = '0;
    end else if (w_of) begin
`ifdef FP_TO_INT_SAT_EN
      w_integ = w_in.sign ? INT_W'(INT_MIN_MAG) : INT_W'(INT_MAX);
`else
      w_integ = '0;
`endif
    end else begin
      w_integ = w_in.sign ? (INT_W'(0) - w_lo) : w_lo;
    end
  end

  // Output register; results hold while in_valid is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld   <= 1'b0;
      r_integ <= '0;
      r_uf    <= 1'b0;
      r_of    <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_integ <= w_integ;
        r_uf    <= w_uf;
        r_of    <= w_of;
      end
    end
  end

  assign out_valid = r_vld;
  assign integ     = r_integ;
  assign uf        = r_uf;
  assign of        = r_of;

endmodule

// File: tb/tb_fp_to_int.sv
// Directed + reference-model bench for fp_to_int. Honors FP_TO_INT_SAT_EN.
module tb_fp_to_int;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       t_sign;
  logic [3:0] t_exp;
  logic [7:0] t_frac;
  logic       out_valid;
  logic [7:0] integ;
  logic       uf;
  logic       of;

  int n_run  = 0;
  int n_fail = 0;

  fp_to_int dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .sign      (t_sign),
    .exp       (t_exp),
    .frac      (t_frac),
    .out_valid (out_valid),
    .integ     (integ),
    .uf        (uf),
    .of        (of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, want);
    end
  endtask

  // Independent arithmetic model: floor(frac * 2^exp / 256).
  task automatic model(input logic s, input logic [3:0] e, input logic [7:0] f,
                       output logic [7:0] iv, output logic u, output logic o);
    int m;
    m  = (int'(f) * (1 << e)) / 256;
    iv = 8'h00; u = 1'b0; o = 1'b0;
    if (f == 8'h00) begin
      iv = 8'h00;
    end else if (m == 0) begin
      u = 1'b1;
    end else if ((s && m > 128) || (!s && m > 127)) begin
      o = 1'b1;
`ifdef FP_TO_INT_SAT_EN
      iv = s ? 8'h80 : 8'h7F;
`endif
    end else begin
      iv = s ? 8'(-m) : 8'(m);
    end
  endtask

  // Drive one valid operand, then sample just after the capturing edge.
  task automatic apply(input logic s, input logic [3:0] e, input logic [7:0] f);
    t_sign = s; t_exp = e; t_frac = f; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic expect3(input string tag, input logic [7:0] iv, input logic u, input logic o);
    chk({tag, ".vld"}, {7'b0, out_valid}, 8'h01);
    chk({tag, ".int"}, integ, iv);
    chk({tag, ".uf"},  {7'b0, uf}, {7'b0, u});
    chk({tag, ".of"},  {7'b0, of}, {7'b0, o});
  endtask

  logic [7:0] pos_tbl [1:7];
  logic [7:0] neg_tbl [1:7];
  logic [7:0] ovf_pos, ovf_neg;
  logic [7:0] m_iv;
  logic       m_u, m_o;

  initial begin
    pos_tbl = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
    neg_tbl = '{8'hFF, 8'hFD, 8'hF9, 8'hF1, 8'hE1, 8'hC1, 8'h81};
`ifdef FP_TO_INT_SAT_EN
    ovf_pos = 8'h7F; ovf_neg = 8'h80;
`else
    ovf_pos = 8'h00; ovf_neg = 8'h00;
`endif

    // 1. reset with toggling inputs
    reset_n = 1'b0; in_valid = 1'b0; t_sign = 1'b0; t_exp = '0; t_frac = '0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom); t_sign = 1'($urandom);
      t_exp = 4'($urandom); t_frac = 8'($urandom);
      @(posedge clk); #1;
      chk("rst.vld", {7'b0, out_valid}, 8'h00);
      chk("rst.int", integ, 8'h00);
      chk("rst.uf",  {7'b0, uf}, 8'h00);
      chk("rst.of",  {7'b0, of}, 8'h00);
    end
    in_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.vld", {7'b0, out_valid}, 8'h00);
    apply(1'b0, 4'd4, 8'hA0);  // 0.625*16 = 10
    expect3("first", 8'h0A, 1'b0, 1'b0);

    // 2. frac=FF, exp 1..7
    for (int e = 1; e <= 7; e++) begin
      apply(1'b0, 4'(e), 8'hFF); expect3($sformatf("pos_e%0d", e), pos_tbl[e], 1'b0, 1'b0);
      apply(1'b1, 4'(e), 8'hFF); expect3($sformatf("neg_e%0d", e), neg_tbl[e], 1'b0, 1'b0);
    end

    // 3. exp=0
    apply(1'b0, 4'd0, 8'hFF); expect3("e0_pos_uf", 8'h00, 1'b1, 1'b0);
    apply(1'b1, 4'd0, 8'hFF); expect3("e0_neg_uf", 8'h00, 1'b1, 1'b0);
    apply(1'b0, 4'd0, 8'h00); expect3("e0_pos_z",  8'h00, 1'b0, 1'b0);
    apply(1'b1, 4'd0, 8'h00); expect3("e0_neg_z",  8'h00, 1'b0, 1'b0);
    apply(1'b0, 4'd3, 8'h10); expect3("uf_e3",     8'h00, 1'b1, 1'b0);

    // 4. exp 8..15
    for (int e = 8; e <= 15; e++) begin
      apply(1'b0, 4'(e), 8'hFF); expect3($sformatf("ovp_e%0d", e), ovf_pos, 1'b0, 1'b1);
      apply(1'b1, 4'(e), 8'hFF); expect3($sformatf("ovn_e%0d", e), ovf_neg, 1'b0, 1'b1);
      apply(1'b1, 4'(e), 8'h00); expect3($sformatf("zero_e%0d", e), 8'h00, 1'b0, 1'b0);
    end

    // 5. boundaries around -128 / +127
    apply(1'b1, 4'd8, 8'h80); expect3("neg128", 8'h80, 1'b0, 1'b0);
    apply(1'b0, 4'd8, 8'h80); expect3("pos128", ovf_pos, 1'b0, 1'b1);
    apply(1'b0, 4'd8, 8'h7F); expect3("pos127", 8'h7F, 1'b0, 1'b0);
    apply(1'b1, 4'd8, 8'h81); expect3("neg129", ovf_neg, 1'b0, 1'b1);
    apply(1'b1, 4'd9, 8'h40); expect3("neg128_e9", 8'h80, 1'b0, 1'b0);
    apply(1'b0, 4'd12, 8'h01); expect3("e12_f01", 8'h10, 1'b0, 1'b0);

    // 6. back-to-back random vs. model
    for (int i = 0; i < 60; i++) begin
      logic s; logic [3:0] e; logic [7:0] f;
      s = 1'($urandom); e = 4'($urandom); f = 8'($urandom);
      model(s, e, f, m_iv, m_u, m_o);
      apply(s, e, f);
      expect3($sformatf("rnd%0d", i), m_iv, m_u, m_o);
    end

    // Deassert mid-stream: outputs hold, out_valid low.
    model(1'b1, 4'd5, 8'hC8, m_iv, m_u, m_o);   // -25
    apply(1'b1, 4'd5, 8'hC8);
    expect3("pre_hold", m_iv, m_u, m_o);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0; t_sign = 1'($urandom); t_exp = 4'($urandom); t_frac = 8'($urandom);
      @(posedge clk); #1;
      chk("hold.vld", {7'b0, out_valid}, 8'h00);
      chk("hold.int", integ, 8'hE7);
      chk("hold.uf",  {7'b0, uf}, 8'h00);
      chk("hold.of",  {7'b0, of}, 8'h00);
    end
    apply(1'b0, 4'd6, 8'h80); expect3("resume", 8'h20, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
